// File: rtl/sseg_anim_ctrl.sv
// Circulating-square animation controller for the lower four digits of an
// 8-digit seven-segment display: run/pause/stop, direction, rate and single-step.
module sseg_anim_ctrl #(
   parameter int unsigned TICK_W = 24
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       stop,
   input  logic       pause,
   input  logic       step,
   input  logic       dir,
   input  logic [1:0] speed,
   output logic [2:0] phase,
   output logic [1:0] state,
   output logic       wrap,
   output logic [7:0] an,
   output logic [7:0] sseg
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10
   } state_t;

   localparam logic [TICK_W-1:0] MAX_COUNT = '1;

   state_t            cur;
   logic [TICK_W-1:0] prescaler;
   logic [TICK_W-1:0] terminal;
   logic              tick;
   logic [2:0]        next_phase;
   logic              wraps;
   logic [3:0]        digit_sel;

   // Terminal follows the live speed input, so lowering it below the current
   // count fires a tick on the very next RUN cycle.
   assign terminal   = MAX_COUNT >> speed;
   assign tick       = (cur == RUN) && (prescaler >= terminal);
   assign next_phase = dir ? (phase - 3'd1) : (phase + 3'd1);
   assign wraps      = dir ? (phase == 3'd0) : (phase == 3'd7);
   assign state      = cur;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur       <= IDLE;
         phase     <= '0;
         prescaler <= '0;
         wrap      <= 1'b0;
      end else begin
         wrap <= 1'b0;
         case (cur)
            IDLE: begin
               if (start && !stop) begin
                  cur       <= RUN;
                  phase     <= '0;
                  prescaler <= '0;
               end
            end
            RUN: begin
               if (stop) begin
                  cur <= IDLE;
               end else if (pause) begin
                  cur <= PAUSE;
               end else if (tick) begin
                  prescaler <= '0;
                  phase     <= next_phase;
                  wrap      <= wraps;
               end else begin
                  prescaler <= prescaler + 1'b1;
               end
            end
            PAUSE: begin
               if (stop) begin
                  cur <= IDLE;
               end else if (pause || start) begin
                  cur <= RUN;
               end else if (step) begin
                  phase <= next_phase;
                  wrap  <= wraps;
               end
            end
            default: cur <= IDLE;
         endcase
      end
   end

   // Upper square walks digits 3->0 for phases 0-3, lower square 0->3 for 4-7.
   always_comb begin
      digit_sel = '0;
      an        = '1;
      sseg      = '1;
      if (cur != IDLE) begin
         if (!phase[2]) begin
            digit_sel = 4'b1000 >> phase[1:0];
            sseg      = 8'b1001_1100;
         end else begin
            digit_sel = 4'b0001 << phase[1:0];
            sseg      = 8'b1010_0011;
         end
         an = {4'hF, ~digit_sel};
      end
   end

endmodule

// File: doc/sseg_anim_ctrl.md
Name: sseg_anim_ctrl

Overview:
- Controller that sequences the circulating-square animation on the lower four digits of the 8-digit seven-segment display.
- Owns run/pause/stop state, rotation direction, animation rate and single-step.
- Drives active-low anodes and segments directly; sits between the debounced button/switch logic and the display pins.

Parameters:
TICK_W, 24, prescaler width; base animation period is 2^TICK_W clk cycles per phase.

Ports:
clk    in   1       system clock
rst    in   1       asynchronous, active-high reset
start  in   1       one-cycle pulse: start from IDLE, resume from PAUSE
stop   in   1       one-cycle pulse: return to IDLE
pause  in   1       one-cycle pulse: toggles RUN<->PAUSE
step   in   1       one-cycle pulse: advance one phase, honoured only in PAUSE
dir    in   1       level: 0 = clockwise (phase+1), 1 = counter-clockwise (phase-1)
speed  in   2       rate select; terminal count = (2^TICK_W-1) >> speed
phase  out  3       current animation phase
state  out  2       00 IDLE, 01 RUN, 10 PAUSE
wrap   out  1       one-cycle pulse when phase wraps (7->0 or 0->7)
an     out  8       anodes, active low
sseg   out  8       segments {dp,g..a}, active low

Behaviour:
- Reset (async): state=IDLE, phase=0, prescaler=0, wrap=0, an=8'hFF, sseg=8'hFF.
- Interface: reset rst, asynchronous, active-high; clock clk. All other state changes on posedge clk.
- FSM priority per cycle: stop > pause > start > step.
  - IDLE: start -> RUN, phase<=0, prescaler<=0. pause and step ignored.
  - RUN: stop -> IDLE. pause -> PAUSE, prescaler held. Otherwise prescaler counts.
  - PAUSE: stop -> IDLE. pause or start -> RUN, prescaler resumes from its held value. step advances phase by one per dir.
  - IDLE -> IDLE on stop: no effect.
- Prescaler:
  - Increments each RUN cycle.
  - tick = (state==RUN) && (prescaler >= terminal), combinational; compare uses the current speed.
  - On tick, prescaler<=0.
  - Lowering terminal mid-run while prescaler exceeds it: tick on the next RUN cycle.
- Phase update:
  - On tick (RUN) or step (PAUSE), phase <= dir ? phase-1 : phase+1, modulo 8.
  - dir is sampled on the advancing edge.
- wrap: registered, asserted for the cycle after an advance that takes phase 7->0 (cw) or 0->7 (ccw). Never asserted by the IDLE->RUN phase clear or by reset.
- Display decode (combinational from state and phase):
  - IDLE: an=8'hFF, sseg=8'hFF.
  - RUN/PAUSE: an[7:4]=4'hF always.
  - Upper square sseg=8'b10011100 for phases 0-3, lit on digits 3,2,1,0 respectively (an[3:0]=0111,1011,1101,1110).
  - Lower square sseg=8'b10100011 for phases 4-7, lit on digits 0,1,2,3 respectively (an[3:0]=1110,1101,1011,0111).
  - Exactly one anode is low outside IDLE.
- Latency: display reflects a new phase in the cycle after the tick/step edge; state output is registered.
- Reset mid-operation: everything returns to reset values immediately; no pending tick or step survives.

Test Plan:
1. TICK_W=4, speed=0, dir=0, start pulse -> state=RUN, phase 0 (an=8'hF7, sseg=8'h9C); phase advances every 16 cycles through 1..7; wrap pulses one cycle after the 7->0 advance.
2. speed=3 while running -> terminal=1, advance every 2 cycles. speed switched 0->3 with prescaler=9 -> tick on the next cycle.
3. dir=1 from phase 0 -> phase 7 (an[3:0]=0111, sseg=8'hA3), wrap=1 for one cycle; continues 6,5,4.
4. pause at prescaler=5 -> PAUSE, phase frozen; two step pulses advance phase by 2; pause again -> RUN, next tick 11 cycles later (resumes from 5).
5. stop, start and pause asserted in the same cycle while RUN -> IDLE, an=8'hFF, sseg=8'hFF. Then start -> phase=0, wrap stays 0.
6. rst asserted asynchronously mid-RUN at phase 5 -> outputs immediately at reset values. step or pause while IDLE -> no change.
